// File: rtl/spi_slave_param_if.sv
// spi_slave_param_if
// Bundles the SPI pins and the on-chip TX/RX word handshake of spi_slave_param.
//   slave  modport : used by spi_slave_param (SPI pins and tx_* in; miso/oe/rx_*/status out)
//   master modport : used by whatever drives the SPI pins and supplies TX words
// DATA_W must match the DATA_W of the attached spi_slave_param.
interface spi_slave_param_if #(
    parameter int DATA_W = 16
) ();
    logic [1:0]        mode;
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              busy;
    logic              frame_err;

    modport slave (
        input  mode, spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid,
               tx_underrun, busy, frame_err
    );

    modport master (
        output mode, spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid,
               tx_underrun, busy, frame_err
    );
endinterface

// File: rtl/spi_slave_param.sv
// spi_slave_param
// Oversampled SPI slave with configurable word width, run-time SPI mode,
// selectable bit order, back-to-back words per frame and a one-entry TX
// holding register with a valid/ready handshake.
// Ports:
//   clk_in : system clock (at least 8x SCLK)
//   rst    : asynchronous active-low reset
//   bus    : spi_slave_param_if.slave (SPI pins, TX/RX word handshake, status)
// Parameters: DATA_W (4..32), SYNC_STAGES (2..4), MSB_FIRST (1 = MSB first).
// Optional feature: define SPI_SLAVE_FRAME_CHECK_EN to pulse frame_err when
// chip select rises in the middle of a word; otherwise frame_err is tied to 0.
module spi_slave_param #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input logic             clk_in,
    input logic             rst,
    spi_slave_param_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic sclk_prev_q, cs_prev_q, mosi_q;
    logic sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, cnt_next;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              sample_edge, load;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    logic              frame_err_q, frame_err_d;
`endif

    // The CS chain resets to "low" so that a chip select already asserted when
    // reset is released never looks like a fresh falling edge. The extra MOSI
    // flop keeps the data aligned with the registered SCLK strobes.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            mosi_q      <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
            sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
            sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
            cs_fall_q   <= ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
            cs_rise_q   <= cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
        end
    end

    // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
    assign sample_edge = (mode_q[1] == mode_q[0]) ? sclk_rise_q : sclk_fall_q;
    assign cnt_next    = bit_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
        frame_err_d = 1'b0;
`endif

        if (state_q == IDLE) begin
            if (cs_fall_q) begin
                state_d   = ACTIVE;
                mode_d    = bus.mode;
                bit_cnt_d = '0;
                load      = 1'b1;
            end
        end else begin
            if (cs_rise_q) begin
                state_d    = IDLE;
                bit_cnt_d  = '0;
                rx_shift_d = '0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
                frame_err_d = (bit_cnt_q != '0);
`endif
            end else if (sample_edge) begin
                if (MSB_FIRST) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_q};
                    tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                end else begin
                    rx_shift_d = {mosi_q, rx_shift_q[DATA_W-1:1]};
                    tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
                end
                if (cnt_next == CNT_W'(DATA_W)) begin
                    rx_data_d  = rx_shift_d;
                    rx_valid_d = 1'b1;
                    bit_cnt_d  = '0;
                    load       = 1'b1;
                end else begin
                    bit_cnt_d = cnt_next;
                end
            end
        end

        // A word load drains the holding register first, then bypasses a word
        // offered this very cycle, and only then falls back to an underrun.
        // Outside a load, an offered word lands in the holding register when empty.
        if (load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else if (bus.tx_valid) begin
                tx_shift_d = bus.tx_data;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end else if (bus.tx_valid && !hold_full_q) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= 2'b00;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    // MISO always shows the outgoing end of the shift register, so the first
    // bit of a word is already present right after its load (needed for CPHA=0).
    assign bus.spi_miso    = MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0];
    assign bus.spi_miso_oe = (state_q == ACTIVE);
    assign bus.busy        = (state_q == ACTIVE);
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    assign bus.frame_err   = frame_err_q;
`else
    assign bus.frame_err   = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param
// Drives two spi_slave_param instances from a behavioural SPI master:
//   dut_a : DATA_W=16, SYNC_STAGES=2, MSB first
//   dut_b : DATA_W=8,  SYNC_STAGES=3, LSB first
// 'sel' chooses which instance the master frame and the TX handshake address.
// Expected words come from a per-instance FIFO model of the words supplied
// to the slave: every word load takes the oldest supplied word or zeros.
module tb_spi_slave_param;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [1:0]  mode;
    logic        sclk, cs_n, mosi;
    logic [31:0] tx_data;
    logic        tx_valid;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] rxq_a[$], rxq_b[$];
    int          und_a, und_b, fe_a, fe_b;
    logic [31:0] model_qa[$], model_qb[$];

    spi_slave_param_if #(.DATA_W(16)) bus_a ();
    spi_slave_param_if #(.DATA_W(8))  bus_b ();

    spi_slave_param #(.DATA_W(16), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut_a (
        .clk_in (clk),
        .rst    (rst_n),
        .bus    (bus_a)
    );

    spi_slave_param #(.DATA_W(8), .SYNC_STAGES(3), .MSB_FIRST(1'b0)) dut_b (
        .clk_in (clk),
        .rst    (rst_n),
        .bus    (bus_b)
    );

    always #5 clk = ~clk;

    assign bus_a.mode     = mode;
    assign bus_a.spi_sclk = sclk;
    assign bus_a.spi_mosi = mosi;
    assign bus_a.spi_cs_n = sel ? 1'b1 : cs_n;
    assign bus_a.tx_data  = tx_data[15:0];
    assign bus_a.tx_valid = tx_valid & ~sel;
    assign bus_b.mode     = mode;
    assign bus_b.spi_sclk = sclk;
    assign bus_b.spi_mosi = mosi;
    assign bus_b.spi_cs_n = sel ? cs_n : 1'b1;
    assign bus_b.tx_data  = tx_data[7:0];
    assign bus_b.tx_valid = tx_valid & sel;

    logic miso_sel, busy_sel, oe_sel, tx_ready_sel;
    assign miso_sel     = sel ? bus_b.spi_miso    : bus_a.spi_miso;
    assign busy_sel     = sel ? bus_b.busy        : bus_a.busy;
    assign oe_sel       = sel ? bus_b.spi_miso_oe : bus_a.spi_miso_oe;
    assign tx_ready_sel = sel ? bus_b.tx_ready    : bus_a.tx_ready;

    // Output monitors sample on the falling clock edge.
    always @(negedge clk) begin
        if (bus_a.rx_valid)    rxq_a.push_back(32'(bus_a.rx_data));
        if (bus_b.rx_valid)    rxq_b.push_back(32'(bus_b.rx_data));
        if (bus_a.tx_underrun) und_a++;
        if (bus_b.tx_underrun) und_b++;
        if (bus_a.frame_err)   fe_a++;
        if (bus_b.frame_err)   fe_b++;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model of one word load: oldest supplied word, or zeros plus an underrun (bit 32).
    function automatic logic [32:0] model_load(input logic s);
        if (s) begin
            if (model_qb.size() > 0) return {1'b0, model_qb.pop_front()};
        end else begin
            if (model_qa.size() > 0) return {1'b0, model_qa.pop_front()};
        end
        return {1'b1, 32'h0};
    endfunction

    function automatic logic [31:0] rx_at(input logic s, input int i);
        if (s) return (rxq_b.size() > i) ? rxq_b[i] : 32'hxxxx_xxxx;
        return (rxq_a.size() > i) ? rxq_a[i] : 32'hxxxx_xxxx;
    endfunction

    // Offers one TX word through the valid/ready handshake of the selected slave.
    task automatic push_tx(input logic [31:0] d);
        int t;
        t = 0;
        while (!tx_ready_sel && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready_sel) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL push_tx: tx_ready stayed %b, required 1", tx_ready_sel);
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            if (sel) model_qb.push_back(d);
            else     model_qa.push_back(d);
        end
    endtask

    // Master side of one word (or the first nbits of it); returns what it saw on MISO.
    task automatic spi_word(input int w, input logic msb, input logic [1:0] md,
                            input logic [31:0] mo, input int nbits, output logic [31:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            automatic int idx = msb ? (w - 1 - i) : i;
            if (!md[0]) begin
                mosi = mo[idx];
                repeat (HALF) @(negedge clk);
                mi[idx] = miso_sel;
                sclk = ~md[1];
                repeat (HALF) @(negedge clk);
                sclk = md[1];
            end else begin
                sclk = ~md[1];
                mosi = mo[idx];
                repeat (HALF) @(negedge clk);
                mi[idx] = miso_sel;
                sclk = md[1];
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    // One chip-select frame of nwords full words, optionally followed by a
    // partial word of 'partial' bits, plus the model's view of the slave words.
    task automatic run_frame(input logic [1:0] md, input int nwords, input logic [31:0] mo [4],
                             input int partial, output logic [31:0] mi [4],
                             output logic [31:0] exp_mi [4], output int exp_under,
                             output logic first_bit, output logic act_ok, output logic idle_ok);
        int          w;
        logic        msb;
        logic [32:0] ld;
        logic [31:0] dummy;
        w = sel ? 8 : 16;
        msb = ~sel;
        exp_under = 0;
        for (int i = 0; i < 4; i++) begin
            mi[i] = '0;
            exp_mi[i] = '0;
        end
        mode = md;
        sclk = md[1];
        mosi = 1'b0;
        repeat (6) @(negedge clk);
        rxq_a.delete();
        rxq_b.delete();
        und_a = 0; und_b = 0; fe_a = 0; fe_b = 0;
        cs_n = 1'b0;
        ld = model_load(sel);
        exp_mi[0] = ld[31:0];
        if (ld[32]) exp_under++;
        repeat (HALF) @(negedge clk);
        first_bit = miso_sel;
        act_ok = busy_sel && oe_sel;
        for (int k = 0; k < nwords; k++) begin
            spi_word(w, msb, md, mo[k], w, mi[k]);
            ld = model_load(sel);
            if (k + 1 < 4) exp_mi[k+1] = ld[31:0];
            if (ld[32]) exp_under++;
        end
        if (partial > 0) spi_word(w, msb, md, mo[nwords], partial, dummy);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        idle_ok = !busy_sel && !oe_sel;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 8;
        if (bus_a.spi_miso !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_miso: got %b want 0", bus_a.spi_miso); end
        if (bus_a.spi_miso_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_oe: got %b want 0", bus_a.spi_miso_oe); end
        if (bus_a.tx_ready !== 1'b1)    begin miscompares++; $display("[TB] FAIL reset_tx_ready: got %b want 1", bus_a.tx_ready); end
        if (bus_a.rx_data !== 16'h0)    begin miscompares++; $display("[TB] FAIL reset_rx_data: got %h want 0", bus_a.rx_data); end
        if (bus_a.rx_valid !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_rx_valid: got %b want 0", bus_a.rx_valid); end
        if (bus_a.tx_underrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_underrun: got %b want 0", bus_a.tx_underrun); end
        if (bus_a.busy !== 1'b0)        begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", bus_a.busy); end
        if (bus_a.frame_err !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_frame_err: got %b want 0", bus_a.frame_err); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_busy: got %b/%b want 0/0", bus_a.busy, bus_b.busy);
        end
    endtask

    task automatic test_mode0();
        logic [31:0] mo[4], mi[4], ex[4];
        int eu;
        logic fb, act, idl;
        sel = 1'b0;
        push_tx(32'hA55A);
        mo[0] = 32'h1234; mo[1] = 0; mo[2] = 0; mo[3] = 0;
        run_frame(2'b00, 1, mo, 0, mi, ex, eu, fb, act, idl);
        vectors += 6;
        if (rxq_a.size() != 1) begin miscompares++; $display("[TB] FAIL mode0_rx_count: got %0d want 1", rxq_a.size()); end
        if (rx_at(1'b0, 0) !== 32'h1234) begin miscompares++; $display("[TB] FAIL mode0_rx: got %h want 1234", rx_at(1'b0, 0)); end
        if (mi[0] !== 32'hA55A) begin miscompares++; $display("[TB] FAIL mode0_miso: got %h want a55a", mi[0]); end
        if (fb !== 1'b1) begin miscompares++; $display("[TB] FAIL mode0_first_bit: got %b want 1", fb); end
        if (und_a != eu) begin miscompares++; $display("[TB] FAIL mode0_underrun: got %0d want %0d", und_a, eu); end
        if (!act || !idl) begin miscompares++; $display("[TB] FAIL mode0_busy_oe: active %b idle %b want 1 1", act, idl); end
    endtask

    task automatic test_modes_123();
        logic [31:0] mo[4], mi[4], ex[4];
        logic [15:0] slave_word;
        int eu;
        logic fb, act, idl;
        sel = 1'b0;
        slave_word = 16'h0F0F;
        for (int m = 1; m <= 3; m++) begin
            push_tx(32'(slave_word));
            mo[0] = 32'hBEEF; mo[1] = 0; mo[2] = 0; mo[3] = 0;
            run_frame(2'(m), 1, mo, 0, mi, ex, eu, fb, act, idl);
            vectors += 3;
            if (rx_at(1'b0, 0) !== 32'hBEEF || rxq_a.size() != 1) begin
                miscompares++;
                $display("[TB] FAIL mode%0d_rx: got %h (count %0d) want beef (count 1)", m, rx_at(1'b0, 0), rxq_a.size());
            end
            if (mi[0] !== 32'h0F0F) begin miscompares++; $display("[TB] FAIL mode%0d_miso: got %h want 0f0f", m, mi[0]); end
            if (und_a != eu) begin miscompares++; $display("[TB] FAIL mode%0d_underrun: got %0d want %0d", m, und_a, eu); end
            if (m == 2) begin
                vectors++;
                if (fb !== slave_word[15]) begin miscompares++; $display("[TB] FAIL mode2_first_bit: got %b want %b", fb, slave_word[15]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] mo[4], mi[4], ex[4], want_mi[3];
        int eu;
        logic fb, act, idl;
        sel = 1'b0;
        push_tx(32'h1111);
        mo[0] = 32'h0001; mo[1] = 32'h0002; mo[2] = 32'h0003; mo[3] = 0;
        want_mi[0] = 32'h1111; want_mi[1] = 32'h2222; want_mi[2] = 32'h0000;
        fork
            run_frame(2'b00, 3, mo, 0, mi, ex, eu, fb, act, idl);
            begin
                repeat (40) @(negedge clk);
                push_tx(32'h2222);
            end
        join
        vectors += 2;
        if (rxq_a.size() != 3) begin miscompares++; $display("[TB] FAIL b2b_rx_count: got %0d want 3", rxq_a.size()); end
        for (int i = 0; i < 3; i++) begin
            vectors += 2;
            if (rx_at(1'b0, i) !== mo[i]) begin miscompares++; $display("[TB] FAIL b2b_rx%0d: got %h want %h", i, rx_at(1'b0, i), mo[i]); end
            if (mi[i] !== want_mi[i]) begin miscompares++; $display("[TB] FAIL b2b_miso%0d: got %h want %h", i, mi[i], want_mi[i]); end
        end
        // Supplied 2 words, 4 loads (frame start + 3 completions): 2 underruns.
        if (und_a != 2) begin miscompares++; $display("[TB] FAIL b2b_underrun: got %0d want 2", und_a); end
    endtask

    task automatic test_lsb_first();
        logic [31:0] mo[4], mi[4], ex[4];
        int eu;
        logic fb, act, idl;
        sel = 1'b1;
        push_tx(32'h81);
        mo[0] = 32'hC3; mo[1] = 0; mo[2] = 0; mo[3] = 0;
        run_frame(2'b00, 1, mo, 0, mi, ex, eu, fb, act, idl);
        vectors += 4;
        if (rxq_b.size() != 1) begin miscompares++; $display("[TB] FAIL lsb_rx_count: got %0d want 1", rxq_b.size()); end
        if (rx_at(1'b1, 0) !== 32'hC3) begin miscompares++; $display("[TB] FAIL lsb_rx: got %h want c3", rx_at(1'b1, 0)); end
        if (mi[0] !== 32'h81) begin miscompares++; $display("[TB] FAIL lsb_miso: got %h want 81", mi[0]); end
        if (!act || !idl) begin miscompares++; $display("[TB] FAIL lsb_busy_oe: active %b idle %b want 1 1", act, idl); end
        sel = 1'b0;
    endtask

    task automatic test_partial_frame();
        logic [31:0] mo[4], mi[4], ex[4];
        int eu, fe_want;
        logic fb, act, idl;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
        fe_want = 1;
`else
        fe_want = 0;
`endif
        sel = 1'b0;
        mo[0] = 32'h1F1F; mo[1] = 0; mo[2] = 0; mo[3] = 0;
        run_frame(2'b00, 0, mo, 5, mi, ex, eu, fb, act, idl);
        vectors += 2;
        if (rxq_a.size() != 0) begin miscompares++; $display("[TB] FAIL partial_rx_count: got %0d want 0", rxq_a.size()); end
        if (fe_a != fe_want) begin miscompares++; $display("[TB] FAIL partial_frame_err: got %0d want %0d", fe_a, fe_want); end
        mo[0] = 32'h2468;
        run_frame(2'b00, 1, mo, 0, mi, ex, eu, fb, act, idl);
        vectors += 2;
        if (rx_at(1'b0, 0) !== 32'h2468 || rxq_a.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL partial_next_rx: got %h (count %0d) want 2468 (count 1)", rx_at(1'b0, 0), rxq_a.size());
        end
        if (fe_a != 0) begin miscompares++; $display("[TB] FAIL partial_next_frame_err: got %0d want 0", fe_a); end
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] mo[4], mi[4], ex[4], junk;
        logic [32:0] ld;
        int eu;
        logic fb, act, idl;
        sel = 1'b0;
        mode = 2'b00;
        sclk = 1'b0;
        push_tx(32'h5A5A);
        repeat (4) @(negedge clk);
        cs_n = 1'b0;
        ld = model_load(1'b0);
        repeat (HALF) @(negedge clk);
        push_tx(32'h3C3C);
        spi_word(16, 1'b1, 2'b00, 32'hFFFF, 3, junk);
        vectors++;
        if (bus_a.tx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pre_tx_ready: got %b want 0", bus_a.tx_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        model_qa.delete();
        model_qb.delete();
        vectors += 5;
        if (bus_a.tx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_tx_ready: got %b want 1", bus_a.tx_ready); end
        if (bus_a.busy !== 1'b0 || bus_a.spi_miso_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy_oe: got %b/%b want 0/0", bus_a.busy, bus_a.spi_miso_oe); end
        if (bus_a.spi_miso !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_miso: got %b want 0", bus_a.spi_miso); end
        if (bus_a.rx_data !== 16'h0 || bus_a.rx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rx: got %h/%b want 0/0", bus_a.rx_data, bus_a.rx_valid); end
        if (bus_a.tx_underrun !== 1'b0 || bus_a.frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pulses: got %b/%b want 0/0", bus_a.tx_underrun, bus_a.frame_err); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (bus_a.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_cs_low_no_frame: busy %b want 0", bus_a.busy); end
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        mo[0] = 32'h1357; mo[1] = 0; mo[2] = 0; mo[3] = 0;
        run_frame(2'b00, 1, mo, 0, mi, ex, eu, fb, act, idl);
        vectors += 3;
        if (rx_at(1'b0, 0) !== 32'h1357 || rxq_a.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL rst_next_rx: got %h (count %0d) want 1357 (count 1)", rx_at(1'b0, 0), rxq_a.size());
        end
        if (mi[0] !== ex[0]) begin miscompares++; $display("[TB] FAIL rst_next_miso: got %h want %h", mi[0], ex[0]); end
        if (und_a != eu) begin miscompares++; $display("[TB] FAIL rst_next_underrun: got %0d want %0d", und_a, eu); end
    endtask

    task automatic test_random();
        logic [31:0] mo[4], mi[4], ex[4], mask;
        int eu, n;
        logic fb, act, idl;
        logic [1:0] md;
        for (int it = 0; it < 8; it++) begin
            sel = 1'($urandom_range(0, 1));
            md = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 3);
            mask = sel ? 32'hFF : 32'hFFFF;
            for (int i = 0; i < 4; i++) mo[i] = $urandom() & mask;
            if ($urandom_range(0, 1) == 1 && (sel ? model_qb.size() : model_qa.size()) == 0)
                push_tx($urandom() & mask);
            run_frame(md, n, mo, 0, mi, ex, eu, fb, act, idl);
            vectors += 3;
            if ((sel ? rxq_b.size() : rxq_a.size()) != n) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_rx_count: got %0d want %0d", it, sel ? rxq_b.size() : rxq_a.size(), n);
            end
            if ((sel ? und_b : und_a) != eu) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_underrun: got %0d want %0d", it, sel ? und_b : und_a, eu);
            end
            if (!act || !idl) begin miscompares++; $display("[TB] FAIL rand%0d_busy_oe: active %b idle %b want 1 1", it, act, idl); end
            for (int k = 0; k < n; k++) begin
                vectors += 2;
                if (rx_at(sel, k) !== mo[k]) begin miscompares++; $display("[TB] FAIL rand%0d_rx%0d: got %h want %h", it, k, rx_at(sel, k), mo[k]); end
                if (mi[k] !== ex[k]) begin miscompares++; $display("[TB] FAIL rand%0d_miso%0d: got %h want %h", it, k, mi[k], ex[k]); end
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        sel = 1'b0;
        mode = 2'b00;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        tx_data = '0;
        tx_valid = 1'b0;
        und_a = 0; und_b = 0; fe_a = 0; fe_b = 0;
        test_reset();
        test_mode0();
        test_modes_123();
        test_back_to_back();
        test_lsb_first();
        test_partial_frame();
        test_reset_mid_word();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
